// File: rtl/sar_adc_ctrl.sv
// 8-bit successive-approximation ADC sequencer driving an external DAC/comparator,
// with a small first-word-fall-through FIFO collecting finished conversions.
module sar_adc_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                        main_clk,
    input  logic                        core_reset,
    input  logic                        start_i,
    input  logic                        comp_in,
    output logic [7:0]                  dac_code,
    output logic                        busy,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [7:0]                  result_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        clear_ovf
);
    localparam int unsigned     PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned     CntW       = PtrW + 1;
    localparam logic [7:0]      SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntFull    = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StSettle, StDecide, StStore} state_e;

    state_e          state_q, state_d;
    logic [7:0]      approx_q, approx_d;
    logic [7:0]      dac_q, dac_d;
    logic [7:0]      settle_q, settle_d;
    logic [2:0]      idx_q, idx_d;
    logic            push;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            pop, full, wr_en, drop;

    always_comb begin
        state_d  = state_q;
        approx_d = approx_q;
        dac_d    = dac_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StSettle;
                    approx_d = 8'h00;
                    idx_d    = 3'd7;
                    dac_d    = 8'h80;
                    settle_d = 8'd0;
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    settle_d = 8'd0;
                    state_d  = StDecide;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            StDecide: begin
                // dac_q is approx plus the trial bit, so keeping the bit means taking dac_q
                approx_d = comp_in ? dac_q : approx_q;
                if (idx_q != 3'd0) begin
                    idx_d   = idx_q - 3'd1;
                    dac_d   = approx_d | (8'h01 << (idx_q - 3'd1));
                    state_d = StSettle;
                end else begin
                    state_d = StStore;
                end
            end
            StStore: begin
                push    = 1'b1;
                dac_d   = 8'h00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop   = (cnt_q != '0) && result_ready;
        full  = (cnt_q == CntFull);
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
        wr_d  = wr_en ? wr_q + PtrW'(1) : wr_q;
        rd_d  = pop ? rd_q + PtrW'(1) : rd_q;
        cnt_d = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        // a drop in the same cycle as a clear leaves the flag set
        ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge main_clk) begin
        if (core_reset) begin
            state_q  <= StIdle;
            approx_q <= 8'h00;
            dac_q    <= 8'h00;
            settle_q <= 8'd0;
            idx_q    <= 3'd0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            approx_q <= approx_d;
            dac_q    <= dac_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge main_clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= approx_q;
        end
    end

    assign dac_code     = dac_q;
    assign busy         = (state_q != StIdle);
    assign result_valid = (cnt_q != '0);
    assign result_data  = mem_q[rd_q];
    assign fifo_count   = cnt_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: an ideal comparator model (vin >= dac_code) closes the loop.
module tb_sar_adc_ctrl;
    logic       main_clk = 1'b0;
    logic       core_reset;
    logic       start_i;
    logic       comp_in;
    logic [7:0] dac_code;
    logic       busy;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] result_data;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clear_ovf;
    logic [7:0] vin;

    int total = 0;
    int bad   = 0;

    logic [7:0] seq_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    always #5 main_clk = ~main_clk;
    assign comp_in = (vin >= dac_code);

    sar_adc_ctrl dut (
        .main_clk     (main_clk),
        .core_reset   (core_reset),
        .start_i      (start_i),
        .comp_in      (comp_in),
        .dac_code     (dac_code),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    task automatic tick();
        @(posedge main_clk);
        @(negedge main_clk);
    endtask

    // Start pulse in cycle 0; returns in cycle 42 (IDLE after STORE) so a following call is
    // back-to-back.
    task automatic conv(input logic [7:0] v);
        vin     = v;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (41) tick();
    endtask

    task automatic test_reset();
        core_reset = 1'b1;
        start_i    = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL reset_dac got=%0h exp=00", dac_code); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", result_valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0h exp=0", overflow); end
        core_reset = 1'b0;
        tick();
        start_i = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_start_busy got=%0h exp=1", busy); end
        total++; if (dac_code !== 8'h80) begin bad++; $display("FAIL first_start_dac got=%0h exp=80", dac_code); end
        core_reset = 1'b1;
        tick();
        core_reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rereset_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_convert_a5();
        vin     = 8'hA5;
        start_i = 1'b1;
        for (int n = 1; n <= 42; n++) begin
            tick();
            start_i = 1'b0;
            if (n <= 40) begin
                total++;
                if (dac_code !== seq_a5[(n - 1) / 5]) begin
                    bad++;
                    $display("FAIL a5_dac cycle=%0d got=%0h exp=%0h", n, dac_code, seq_a5[(n - 1) / 5]);
                end
            end
            if (n == 41) begin
                total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL a5_valid_early got=%0h exp=0", result_valid); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL a5_busy_store got=%0h exp=1", busy); end
            end
        end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL a5_valid_42 got=%0h exp=1", result_valid); end
        total++; if (result_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%0h exp=a5", result_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy_idle got=%0h exp=0", busy); end
        total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL a5_dac_idle got=%0h exp=00", dac_code); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL a5_pop_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_extremes();
        logic [7:0] vals [2] = '{8'h00, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            vin     = vals[k];
            start_i = 1'b1;
            for (int n = 1; n <= 42; n++) begin
                tick();
                start_i = (n == 10);
            end
            total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL ext_valid k=%0d got=%0h exp=1", k, result_valid); end
            total++; if (result_data !== vals[k]) begin bad++; $display("FAIL ext_data k=%0d got=%0h exp=%0h", k, result_data, vals[k]); end
            repeat (50) tick();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL ext_nobusy k=%0d got=%0h exp=0", k, busy); end
            total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL ext_count k=%0d got=%0d exp=1", k, fifo_count); end
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) conv(8'h10 + 8'(k));
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (result_valid !== 1'b1 || result_data !== 8'h10 + 8'(k)) begin
                bad++;
                $display("FAIL ovf_drain k=%0d got=%0h/%0h exp=1/%0h", k, result_valid, result_data, 8'h10 + 8'(k));
            end
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
        end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0h exp=0", result_valid); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL ovf_empty_pop got=%0d exp=0", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h exp=1", overflow); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0h exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 4; k++) conv(8'h10 + 8'(k));
        vin     = 8'h14;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (40) tick();
        total++; if (result_data !== 8'h10) begin bad++; $display("FAIL fpp_head got=%0h exp=10", result_data); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%0h exp=0", overflow); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fpp_count got=%0d exp=4", fifo_count); end
        total++; if (result_data !== 8'h11) begin bad++; $display("FAIL fpp_newhead got=%0h exp=11", result_data); end
        clear_ovf = 1'b1;
        conv(8'h20);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_beats_clear got=%0h exp=1", overflow); end
        tick();
        clear_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_clear got=%0h exp=0", overflow); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (result_data !== 8'h11 + 8'(k)) begin
                bad++;
                $display("FAIL fpp_drain k=%0d got=%0h exp=%0h", k, result_data, 8'h11 + 8'(k));
            end
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
        end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL fpp_final_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        conv(8'h33);
        vin     = 8'h77;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (19) tick();
        core_reset = 1'b1;
        tick();
        core_reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0h exp=0", busy); end
        total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL mid_dac got=%0h exp=00", dac_code); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
        conv(8'h5A);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL mid_new_count got=%0d exp=1", fifo_count); end
        total++; if (result_data !== 8'h5A) begin bad++; $display("FAIL mid_new_data got=%0h exp=5a", result_data); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        result_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            v = 8'(k * 37 + 5);
            conv(v);
            total++;
            if (result_data !== v || fifo_count !== 3'd1) begin
                bad++;
                $display("FAIL wrap k=%0d got=%0h/%0d exp=%0h/1", k, result_data, fifo_count, v);
            end
        end
        tick();
        result_ready = 1'b0;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL wrap_empty got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        core_reset   = 1'b1;
        start_i      = 1'b0;
        result_ready = 1'b0;
        clear_ovf    = 1'b0;
        vin          = 8'h00;
        test_reset();
        test_convert_a5();
        test_extremes();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
